// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants and enums for the VGA text-buffer arbiter
package vga_text_pkg;
    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 30;
    localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;
    localparam int CHAR_W = 8;
    localparam int CHAR_H = 16;
    localparam logic [9:0] PIX_BLANK = 10'h3FF;
    localparam logic [7:0] CLR_CHAR_DEF = 8'h20;

    typedef enum logic [2:0] {G_NONE, G_DISP, G_CLR, G_HOST, G_RD} grant_t;
    typedef enum logic {S_IDLE, S_CLEAR} state_t;
endpackage

// File: rtl/text_addr_calc.sv
// rtl/text_addr_calc.sv - row*80+col cell address via shift-add, plus cell-range check
module text_addr_calc #(
    parameter int ADDR_W = 12,
    parameter int CELLS  = 2400
) (
    input  logic [5:0]        row,
    input  logic [6:0]        col,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              chk_ok
);
    // 80 = 64 + 16, so no multiplier is needed
    assign addr   = (ADDR_W'(row) << 6) + (ADDR_W'(row) << 4) + ADDR_W'(col);
    assign chk_ok = (chk_addr < ADDR_W'(CELLS));
endmodule

// File: rtl/vga_text_arbiter.sv
// rtl/vga_text_arbiter.sv - char-buffer RAM arbiter (display > clear > host write); optional host reads under HOST_RD_EN
module vga_text_arbiter
    import vga_text_pkg::*;
#(
    parameter int         TEXT_COLS = 80,
    parameter int         TEXT_ROWS = 30,
    parameter int         ADDR_W    = 12,
    parameter logic [7:0] CLR_CHAR  = 8'h20
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              err_addr,
`ifdef HOST_RD_EN
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_data_valid,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        char_code,
    output logic              char_valid
);
    localparam int CELLS = TEXT_COLS * TEXT_ROWS;

    state_t            state, next_state;
    grant_t            grant;
    logic [ADDR_W-1:0] clr_cnt;
    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_data;
    logic              disp_rd_d, blank_d1;
    logic              disp_slot, wr_ok, wr_accept;
    logic [ADDR_W-1:0] disp_addr;

    assign disp_slot = (pix_x != PIX_BLANK) && (pix_y != PIX_BLANK) && (pix_x[2:0] == 3'd0);

    text_addr_calc #(.ADDR_W(ADDR_W), .CELLS(CELLS)) u_addr_calc (
        .row      (pix_y[9:4]),
        .col      (pix_x[9:3]),
        .chk_addr (wr_addr),
        .addr     (disp_addr),
        .chk_ok   (wr_ok)
    );

    assign wr_ready  = ~hold_full;
    assign wr_accept = wr_valid && !hold_full && !sys_rst;
    assign err_addr  = wr_accept && !wr_ok;
    assign clr_busy  = (state == S_CLEAR);

`ifdef HOST_RD_EN
    logic              rd_full, rd_pend, rd_pend_ok, rd_ok_q, rd_accept;
    logic [ADDR_W-1:0] rd_addr_q;

    assign rd_ready      = ~rd_full;
    assign rd_accept     = rd_valid && !rd_full && !sys_rst;
    assign rd_ok_q       = (rd_addr_q < ADDR_W'(CELLS));
    assign rd_data       = rd_pend_ok ? ram_rdata : 8'h00;
    assign rd_data_valid = rd_pend;

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            rd_full    <= 1'b0;
            rd_addr_q  <= '0;
            rd_pend    <= 1'b0;
            rd_pend_ok <= 1'b0;
        end else begin
            if (rd_accept) begin
                rd_full   <= 1'b1;
                rd_addr_q <= rd_addr;
            end else if (grant == G_RD) begin
                rd_full <= 1'b0;
            end
            rd_pend    <= (grant == G_RD);
            rd_pend_ok <= (grant == G_RD) && rd_ok_q;
        end
    end
`endif

    // Grants are suppressed during reset so an aborted sweep issues no further writes
    always_comb begin
        grant      = G_NONE;
        next_state = state;
        if (!sys_rst) begin
            if (disp_slot)
                grant = G_DISP;
            else if (state == S_CLEAR)
                grant = G_CLR;
            else if (hold_full)
                grant = G_HOST;
`ifdef HOST_RD_EN
            else if (rd_full)
                grant = G_RD;
`endif
        end
        case (state)
            S_IDLE:  if (clr_req) next_state = S_CLEAR;
            S_CLEAR: if (grant == G_CLR && clr_cnt == ADDR_W'(CELLS - 1)) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 8'h00;
        case (grant)
            G_DISP: begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
            end
            G_CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = CLR_CHAR;
            end
            G_HOST: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = hold_addr;
                ram_wdata = hold_data;
            end
`ifdef HOST_RD_EN
            G_RD: begin
                ram_en   = rd_ok_q;
                ram_addr = rd_addr_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            clr_cnt   <= '0;
            hold_full <= 1'b0;
            hold_addr <= '0;
            hold_data <= 8'h00;
        end else begin
            state <= next_state;
            if (grant == G_CLR)
                clr_cnt <= (clr_cnt == ADDR_W'(CELLS - 1)) ? '0 : clr_cnt + ADDR_W'(1);
            // Out-of-range writes are acknowledged but never occupy the hold register
            if (wr_accept && wr_ok) begin
                hold_full <= 1'b1;
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end else if (grant == G_HOST) begin
                hold_full <= 1'b0;
            end
        end
    end

    // Fetch issued at cell offset 0, data on ram_rdata at offset 1, registered for offset 2
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            disp_rd_d  <= 1'b0;
            blank_d1   <= 1'b0;
            char_code  <= 8'h00;
            char_valid <= 1'b0;
        end else begin
            disp_rd_d <= (grant == G_DISP);
            blank_d1  <= (pix_x == PIX_BLANK);
            if (disp_rd_d) begin
                char_code  <= ram_rdata;
                char_valid <= 1'b1;
            end else if (blank_d1) begin
                char_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vga_text_arbiter.sv
// tb/tb_vga_text_arbiter.sv - scoreboard bench for vga_text_arbiter with RAM and char-buffer reference model
module tb_vga_text_arbiter;
    localparam int AW = 12;
    localparam logic [9:0] BLK = 10'h3FF;

    logic          vga_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [9:0]    pix_x = BLK, pix_y = BLK;
    logic          wr_valid = 1'b0, wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr_req = 1'b0, clr_busy, err_addr;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;
    logic [7:0]    char_code;
    logic          char_valid;
`ifdef HOST_RD_EN
    logic          rd_valid = 1'b0, rd_ready, rd_data_valid;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
`endif

    vga_text_arbiter dut (
        .vga_clk   (vga_clk),
        .sys_rst   (sys_rst),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .err_addr  (err_addr),
`ifdef HOST_RD_EN
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
`endif
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .char_code (char_code),
        .char_valid(char_valid)
    );

    always #20 vga_clk = ~vga_clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ram_mem [0:4095];
    logic [7:0] ref_mem [0:2399];

    always @(posedge vga_clk)
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end

    typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic chk; logic [7:0] c; } dq_t;
    wr_t wq[$];
    dq_t dq[$];
    wr_t w;
    dq_t e;
    int busy_cnt = 0;
    logic [9:0] h1x = BLK, h1y = BLK, h2x = BLK, h2y = BLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got event expected none", name);
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drive_pixel(input logic [9:0] x, input logic [9:0] y, input bit want);
        dq_t t;
        pix_x = x;
        pix_y = y;
        if (x != BLK && y != BLK && x[2:0] == 3'd0) begin
            t.chk = want;
            t.c   = want ? ref_mem[int'(y[9:4]) * 80 + int'(x[9:3])] : 8'h00;
            dq.push_back(t);
        end
    endtask

    // Monitor: every RAM write must match the next expected write; every cell shows its char 2 cycles after its fetch
    always @(negedge vga_clk) begin
        if (ram_en === 1'b1 && ram_we === 1'b1) begin
            if (wq.size() == 0) fail("ram_write_unexpected");
            else begin
                w = wq.pop_front();
                chk("ram_wr_addr", ram_addr, w.a);
                chk("ram_wr_data", ram_wdata, w.d);
            end
        end
        if (h2x != BLK && h2y != BLK && h2x[2:0] == 3'd0) begin
            if (dq.size() == 0) fail("disp_queue_underflow");
            else begin
                e = dq.pop_front();
                if (e.chk) begin
                    chk("char_code", char_code, e.c);
                    chk("char_valid", char_valid, 1);
                end
            end
        end
        if (clr_busy === 1'b1) busy_cnt++;
        h2x = h1x; h2y = h1y; h1x = pix_x; h1y = pix_y;
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        bit done = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge vga_clk);
            if (wr_ready) begin
                done = 1;
                chk("err_addr", err_addr, (a >= 2400));
                if (a < 2400) begin
                    wq.push_back({a, d});
                    ref_mem[a] = d;
                end
            end
            step();
        end
        wr_valid = 1'b0;
        if (!done) fail("host_write_timeout");
    endtask

    task automatic disp_run(input int row, input int col, input int n);
        for (int c = col; c < col + n; c++) begin
            logic [9:0] y;
            y = 10'(row * 16 + $urandom_range(0, 15));
            for (int off = 0; off < 8; off++) begin
                drive_pixel(10'(c * 8 + off), y, 1'b1);
                step();
            end
        end
        drive_pixel(BLK, BLK, 1'b0);
        repeat (3) step();
    endtask

`ifdef HOST_RD_EN
    task automatic host_read(input logic [AW-1:0] a, input logic [7:0] exp, input bit noram);
        bit done = 0;
        rd_valid = 1'b1; rd_addr = a;
        step();
        rd_valid = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge vga_clk);
            if (noram && ram_en) fail("rd_oob_ram_en");
            if (rd_data_valid) begin
                done = 1;
                chk("rd_data", rd_data, exp);
            end
            step();
        end
        if (!done) fail("rd_timeout");
    endtask
`endif

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [7:0] d;
        for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
        for (int i = 0; i < 2400; i++) begin
            d = 8'($urandom);
            ram_mem[i] = d;
            ref_mem[i] = d;
        end
        ram_mem[81] = 8'h41;
        ref_mem[81] = 8'h41;

        repeat (3) step();
        sys_rst = 1'b0;
        @(negedge vga_clk);
        chk("rst_clr_busy", clr_busy, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_err_addr", err_addr, 0);
        step();

        // Cell (row 1, col 1) = address 81
        for (int x = 8; x < 16; x++) begin
            drive_pixel(10'(x), 10'd16, 1'b1);
            @(negedge vga_clk);
            if (x == 8) begin
                chk("disp_ram_en", ram_en, 1);
                chk("disp_ram_we", ram_we, 0);
                chk("disp_ram_addr", ram_addr, 81);
            end
            if (x == 9)  chk("char_valid_x9", char_valid, 0);
            if (x == 10) chk("char_valid_x10", char_valid, 1);
            step();
        end
        drive_pixel(BLK, 10'd16, 1'b0);
        @(negedge vga_clk); chk("char_valid_blank_t0", char_valid, 1);
        step();
        @(negedge vga_clk); chk("char_valid_blank_t1", char_valid, 1);
        step();
        @(negedge vga_clk); chk("char_valid_blank_t2", char_valid, 0);
        step();
        drive_pixel(BLK, BLK, 1'b0);

`ifdef HOST_RD_EN
        host_read(12'd81, 8'h41, 1'b0);
        host_read(12'd3000, 8'h00, 1'b1);
`endif

        // Host write against a display slot
        drive_pixel(10'd16, 10'd0, 1'b0);
        wr_valid = 1'b1; wr_addr = 12'd5; wr_data = 8'h5A;
        @(negedge vga_clk);
        chk("hw_ready_x16", wr_ready, 1);
        wq.push_back({12'd5, 8'h5A});
        ref_mem[5] = 8'h5A;
        step();
        wr_valid = 1'b0;
        drive_pixel(10'd17, 10'd0, 1'b0);
        @(negedge vga_clk);
        chk("hw_ready_x17", wr_ready, 0);
        chk("hw_we_x17", ram_we, 1);
        chk("hw_addr_x17", ram_addr, 5);
        step();
        drive_pixel(10'd18, 10'd0, 1'b0);
        @(negedge vga_clk);
        chk("hw_ready_x18", wr_ready, 1);
        step();
        drive_pixel(BLK, BLK, 1'b0);
        step();

        host_write(12'd2400, 8'hEE);
        @(negedge vga_clk);
        chk("oob_wr_ready", wr_ready, 1);
        step();

        repeat (20) host_write(12'($urandom_range(0, 2599)), 8'($urandom));
        repeat (4) begin
            a = 12'($urandom_range(0, 2399));
            host_write(a, 8'($urandom));
            step();
            disp_run(int'(a) / 80, int'(a) % 80, 1);
        end
        repeat (6) begin
            int n, r, c;
            n = $urandom_range(1, 8);
            r = $urandom_range(0, 29);
            c = $urandom_range(0, 80 - n);
            disp_run(r, c, n);
        end

        // Sweep aborted by reset after 50 writes
        for (int i = 0; i < 50; i++) begin
            wq.push_back({12'(i), 8'h20});
            ref_mem[i] = 8'h20;
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (50) step();
        sys_rst = 1'b1;
        repeat (3) step();
        sys_rst = 1'b0;
        @(negedge vga_clk);
        chk("abort_clr_busy", clr_busy, 0);
        chk("abort_ram_en", ram_en, 0);
        chk("abort_wr_ready", wr_ready, 1);
        chk("abort_writes_left", wq.size(), 0);
        step();

        // Full sweep from address 0 with a host write queued behind it
        for (int i = 0; i < 2400; i++) begin
            wq.push_back({12'(i), 8'h20});
            ref_mem[i] = 8'h20;
        end
        busy_cnt = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        host_write(12'd7, 8'hC3);
        begin
            bit fell = 0;
            for (int i = 0; i < 3000 && !fell; i++) begin
                @(negedge vga_clk);
                if (!clr_busy) begin
                    fell = 1;
                    chk("sweep_cycles", busy_cnt, 2400);
                    chk("post_sweep_we", ram_we, 1);
                    chk("post_sweep_addr", ram_addr, 7);
                    chk("post_sweep_data", ram_wdata, 8'hC3);
                end
                step();
            end
            if (!fell) fail("sweep_timeout");
        end
        disp_run(0, 4, 6);
        disp_run(29, 72, 8);

        repeat (4) step();
        chk("writes_drained", wq.size(), 0);
        chk("disp_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_text_arbiter.md
Name: vga_text_arbiter

Overview:
- Owns the single-port character buffer RAM of 80x30 cells (8x16 font, 640x480) between the VGA timing block and the picture block.
- Arbitrates each cycle between three users: display fetch (hard deadline), screen-clear sweep, and a host write port (valid/ready).
- Presents the char code of the current cell to the picture generator; the picture generator does the font lookup.

Parameters:
TEXT_COLS, 80, characters per row
TEXT_ROWS, 30, character rows
ADDR_W, 12, RAM address width (must cover TEXT_COLS*TEXT_ROWS-1)
CLR_CHAR, 8'h20, code written by clear sweep

Ports:
vga_clk  in  1  VGA working clock, 25MHz
sys_rst  in  1  reset, synchronous, active-high
pix_x  in  10  current pixel x; 10'h3FF = blanking
pix_y  in  10  current pixel y; 10'h3FF = blanking
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted when valid&ready
wr_addr  in  ADDR_W  host cell address
wr_data  in  8  host char code
clr_req  in  1  start clear sweep (level sampled)
clr_busy  out  1  clear sweep in progress
err_addr  out  1  1-cycle pulse: accepted write had addr >= 2400
ram_en, ram_we  out  1  RAM enable / write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, 1-cycle latency
char_code  out  8  char of current cell
char_valid  out  1  char_code belongs to current cell

Behaviour:
- Reset: all outputs 0 except wr_ready=1; hold register empty; FSM=S_IDLE; clear counter=0. Reset mid-sweep aborts the sweep with no further RAM writes.
- disp_slot = (pix_x!=3FF) & (pix_y!=3FF) & (pix_x[2:0]==0).
- Display address = (pix_y[9:4])*80 + pix_x[9:3], computed as (r<<6)+(r<<4)+c, ADDR_W bits, max 2399.
- Display latency:
  - Read issued at cell offset 0; ram_rdata is valid at offset 1.
  - char_code/char_valid are registered at offset 2 and hold until the next cell's offset 2.
  - The picture generator delays pix_x by 2 cycles to compensate.
- char_valid clears 2 cycles after the cycle in which pix_x becomes 3FF.
- Grant priority, evaluated each cycle: DISP > CLR > HOST > none. Only the granted user drives ram_*; with no grant, ram_en=0.
- FSM:
  - S_IDLE -> S_CLEAR when clr_req=1.
  - In S_CLEAR: on each CLR grant, write CLR_CHAR to counter address, then counter++.
  - After the write of address 2399: counter -> 0, return to S_IDLE.
  - clr_busy=1 exactly while in S_CLEAR. clr_req is ignored while busy.
- Host path:
  - 1-deep hold register; wr_ready = ~hold_full.
  - On a HOST grant, write the hold register to RAM and empty it. wr_ready rises the next cycle.
  - A simultaneous accept and drain in the same cycle is not allowed (wr_ready is low while full).
  - Writes with addr >= 2400 are accepted, never reach RAM, and pulse err_addr in the accept cycle.
  - A write to an address the display reads in the same cycle is not possible, because the display wins. Display sees the new value from the next fetch.
- Guarantee: outside blanking, 7 of 8 cycles are free, so a host write waits at most 1 cycle outside S_CLEAR. During S_CLEAR, host writes stall until the sweep ends.

Optional Feature:
- Macro HOST_RD_EN.
- When defined, adds ports:
  - rd_valid in 1
  - rd_ready out 1
  - rd_addr in ADDR_W
  - rd_data out 8
  - rd_data_valid out 1
- Host reads:
  - 1-deep read request register; grant priority below HOST write.
  - rd_data/rd_data_valid appear 1 cycle after the read grant; rd_data_valid is a 1-cycle pulse.
  - Reads with addr >= 2400 return 8'h00 with rd_data_valid and never touch RAM.
- When undefined: no read ports, no read register; arbitration has three users only.

Decomposition:
- Package vga_text_pkg: TEXT_COLS, TEXT_ROWS, TEXT_CELLS=2400, CHAR_W=8, CHAR_H=16, PIX_BLANK=10'h3FF, CLR_CHAR default, grant enum {G_NONE, G_DISP, G_CLR, G_HOST, G_RD}, FSM enum {S_IDLE, S_CLEAR}.
- One sub-module, text_addr_calc: combinational row*80+col with shift-add and range check. It is used for the display address and for host address validation.

Test Plan:
- Reset with sys_rst=1 for 3 cycles mid-sweep -> clr_busy=0, ram_en=0, wr_ready=1; clear counter restarts at 0 on the next clr_req.
- Preload RAM[81]=8'h41; drive pix_y=16, pix_x=8..15 -> ram_addr=81 at pix_x=8; char_code=8'h41 with char_valid=1 from pix_x=10.
- Host write addr 5, data 8'h5A, issued at pix_x=16 (disp_slot) -> wr_ready=0 one cycle; RAM write at pix_x=17; wr_ready=1 at pix_x=18.
- Host write addr 2400 -> err_addr pulse; no ram_we; wr_ready stays 1.
- clr_req during blanking -> 2400 consecutive writes of 8'h20 to addresses 0..2399; clr_busy high exactly 2400 cycles; queued host write lands on the cycle after clr_busy falls.
- HOST_RD_EN: read addr 81 -> rd_data=8'h41, rd_data_valid 1 cycle after grant; read addr 3000 -> 8'h00, no ram_en.
